aes_ctr_wide_fsm: RTL and testbench

AES_CTR_WIDE_FSM -- requirements
Module: aes_ctr_wide_fsm

---
 rtl/aes_pkg.sv | 15 +
 rtl/aes_ctr_slice_add.sv | 16 +
 rtl/aes_ctr_wide_fsm.sv | 126 ++++++++++++
 tb/tb_aes_ctr_wide_fsm.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and defaults for the wide AES counter increment slice.
// The state encoding is sparse so that single and double bit upsets never land on another valid state.
package aes_pkg;

   localparam int unsigned CtrSliceSizeDefault = 16;
   localparam int unsigned CtrNumSlicesDefault = 8;

   // Pairwise Hamming distances: IDLE/INCR 5, IDLE/ERROR 4, INCR/ERROR 3.
   typedef enum logic [5:0] {
      CTR_IDLE  = 6'b001011,
      CTR_INCR  = 6'b110101,
      CTR_ERROR = 6'b100000
   } aes_ctr_wide_e;

endpackage

// File: rtl/aes_ctr_slice_add.sv
// Combinational slice adder; the extra MSB of the sum is the carry into the next slice.
module aes_ctr_slice_add #(
   parameter int unsigned SliceSize = 16
) (
   input  logic [SliceSize-1:0] a,
   input  logic [SliceSize-1:0] b,
   output logic [SliceSize-1:0] sum,
   output logic                 carry
);

   logic [SliceSize:0] sum_full;

   assign sum_full     = {1'b0, a} + {1'b0, b};
   assign {carry, sum} = sum_full;

endmodule

// File: rtl/aes_ctr_wide_fsm.sv
// Wide counter incrementer: walks the counter one slice per cycle, stopping as soon as
// the carry dies out or the top active slice (32-bit or full width) has been written.
module aes_ctr_wide_fsm
   import aes_pkg::*;
#(
   parameter int unsigned SliceSize = CtrSliceSizeDefault,
   parameter int unsigned NumSlices = CtrNumSlicesDefault,
   localparam int unsigned SliceIdxW = (NumSlices > 1) ? $clog2(NumSlices) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 incr_i,
   input  logic [SliceSize-1:0] incr_step_i,
   input  logic                 inc32_i,
   output logic                 ready_o,
   output logic                 done_o,
   output logic                 ovf_o,
   input  logic                 err_i,
   output logic                 alert_o,
   output logic [SliceIdxW-1:0] ctr_slice_idx_o,
   input  logic [SliceSize-1:0] ctr_slice_i,
   output logic [SliceSize-1:0] ctr_slice_o,
   output logic                 ctr_we_o
);

   localparam int unsigned LastIdx32   = 32 / SliceSize - 1;
   localparam int unsigned LastIdxFull = NumSlices - 1;

   if (!(SliceSize == 8 || SliceSize == 16 || SliceSize == 32)) begin : gen_bad_slice_size
      $error("aes_ctr_wide_fsm: SliceSize must be 8, 16 or 32");
   end
   if (NumSlices * SliceSize < 32) begin : gen_bad_num_slices
      $error("aes_ctr_wide_fsm: NumSlices*SliceSize must be at least 32");
   end

   // SEC_CM: CTR.FSM.SPARSE
   // SEC_CM: CTR.FSM.LOCAL_ESC
   aes_ctr_wide_e        state_reg;
   logic [SliceIdxW-1:0] idx_reg;
   logic                 carry_reg;
   logic [SliceSize-1:0] step_reg;
   logic                 mode_reg;

   logic [SliceSize-1:0] addend;
   logic [SliceSize-1:0] sum;
   logic                 carry_out;
   logic [SliceIdxW-1:0] last_idx;
   logic                 is_last;
   logic                 finish;

   // Only slice 0 takes the step; higher slices only ever absorb a single carry.
   assign addend   = (idx_reg == '0) ? step_reg : {{(SliceSize-1){1'b0}}, carry_reg};
   assign last_idx = mode_reg ? SliceIdxW'(LastIdx32) : SliceIdxW'(LastIdxFull);
   assign is_last  = (idx_reg == last_idx);
   assign finish   = !carry_out || is_last;

   aes_ctr_slice_add #(
      .SliceSize(SliceSize)
   ) u_slice_add (
      .a    (ctr_slice_i),
      .b    (addend),
      .sum  (sum),
      .carry(carry_out)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= CTR_IDLE;
         idx_reg   <= '0;
         carry_reg <= 1'b0;
         step_reg  <= '0;
         mode_reg  <= 1'b0;
      end else if (err_i) begin
         state_reg <= CTR_ERROR;
      end else begin
         case (state_reg)
            CTR_IDLE: begin
               if (incr_i) begin
                  step_reg  <= incr_step_i;
                  mode_reg  <= inc32_i;
                  idx_reg   <= '0;
                  carry_reg <= 1'b0;
                  state_reg <= CTR_INCR;
               end
            end
            CTR_INCR: begin
               if (finish) begin
                  idx_reg   <= '0;
                  carry_reg <= 1'b0;
                  state_reg <= CTR_IDLE;
               end else begin
                  idx_reg   <= idx_reg + SliceIdxW'(1);
                  carry_reg <= carry_out;
               end
            end
            CTR_ERROR: state_reg <= CTR_ERROR;
            default:   state_reg <= CTR_ERROR;
         endcase
      end
   end

   // Anything other than IDLE or INCR (ERROR or a corrupted encoding) raises the alert.
   always_comb begin
      ready_o  = 1'b0;
      ctr_we_o = 1'b0;
      done_o   = 1'b0;
      ovf_o    = 1'b0;
      alert_o  = 1'b1;
      if (state_reg == CTR_IDLE) begin
         ready_o = 1'b1;
         alert_o = 1'b0;
      end else if (state_reg == CTR_INCR) begin
         ctr_we_o = 1'b1;
         done_o   = finish;
         ovf_o    = is_last && carry_out;
         alert_o  = 1'b0;
      end
   end

   assign ctr_slice_o     = sum;
   assign ctr_slice_idx_o = idx_reg;

   assert property (@(posedge clk_i) disable iff (rst_i)
      !alert_o |-> (state_reg == CTR_IDLE || state_reg == CTR_INCR));

endmodule

// File: tb/tb_aes_ctr_wide_fsm.sv
// Scoreboard bench: a 128-bit arithmetic reference predicts every slice write, a monitor checks them.
module tb_aes_ctr_wide_fsm;

   localparam int S = 16;
   localparam int N = 8;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          incr_i;
   logic [S-1:0]  incr_step_i;
   logic          inc32_i;
   logic          ready_o;
   logic          done_o;
   logic          ovf_o;
   logic          err_i;
   logic          alert_o;
   logic [2:0]    ctr_slice_idx_o;
   logic [S-1:0]  ctr_slice_i;
   logic [S-1:0]  ctr_slice_o;
   logic          ctr_we_o;

   typedef struct {
      int          idx;
      logic [15:0] data;
      logic        done;
      logic        ovf;
   } exp_t;

   exp_t         sb_q[$];
   logic [127:0] ref_ctr;
   logic [S-1:0] mem [N];
   logic         load_en;
   logic [127:0] load_val;
   int           checks = 0;
   int           errors = 0;

   aes_ctr_wide_fsm dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .incr_i         (incr_i),
      .incr_step_i    (incr_step_i),
      .inc32_i        (inc32_i),
      .ready_o        (ready_o),
      .done_o         (done_o),
      .ovf_o          (ovf_o),
      .err_i          (err_i),
      .alert_o        (alert_o),
      .ctr_slice_idx_o(ctr_slice_idx_o),
      .ctr_slice_i    (ctr_slice_i),
      .ctr_slice_o    (ctr_slice_o),
      .ctr_we_o       (ctr_we_o)
   );

   always #5 clk_i = ~clk_i;

   assign ctr_slice_i = mem[ctr_slice_idx_o];

   always @(posedge clk_i) begin
      if (load_en) begin
         for (int k = 0; k < N; k++) mem[k] <= load_val[k*S +: S];
      end else if (ctr_we_o) begin
         mem[ctr_slice_idx_o] <= ctr_slice_o;
      end
   end

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [127:0] mem_value();
      logic [127:0] v;
      for (int k = 0; k < N; k++) v[k*S +: S] = mem[k];
      return v;
   endfunction

   task automatic set_ctr(input logic [127:0] v);
      load_val = v;
      load_en  = 1'b1;
      ref_ctr  = v;
      @(posedge clk_i);
      #1 load_en = 1'b0;
   endtask

   // Predict the write sequence purely from integer arithmetic on the whole counter.
   task automatic predict(input logic [15:0] step, input logic mode, output int nw);
      int           last;
      logic [128:0] lim;
      logic [128:0] low;
      logic         c;
      logic [127:0] nv;
      exp_t         e;
      last = mode ? 1 : 7;
      if (mode) nv = {ref_ctr[127:32], ref_ctr[31:0] + {16'h0, step}};
      else      nv = ref_ctr + {112'h0, step};
      nw = 0;
      for (int k = 0; k <= last; k++) begin
         lim    = 129'(1) << (16 * (k + 1));
         low    = {1'b0, ref_ctr} & (lim - 129'(1));
         c      = (low + {113'h0, step}) >= lim;
         e.idx  = k;
         e.data = nv[16*k +: 16];
         e.done = !c || (k == last);
         e.ovf  = c && (k == last);
         sb_q.push_back(e);
         nw++;
         if (e.done) break;
      end
      ref_ctr = nv;
   endtask

   task automatic run_incr(input logic [15:0] step, input logic mode, input logic poke);
      int nw;
      int n;
      @(negedge clk_i);
      chk("ready_before_op", 128'(ready_o), 128'(1));
      predict(step, mode, nw);
      $display("op step=%h inc32=%0d expected_writes=%0d", step, mode, nw);
      incr_i      = 1'b1;
      incr_step_i = step;
      inc32_i     = mode;
      @(negedge clk_i);
      incr_i = 1'b0;
      n = 0;
      while (!ready_o && n < 20) begin
         incr_i      = poke && ($urandom_range(0, 1) == 1);
         incr_step_i = 16'($urandom);
         @(negedge clk_i);
         n++;
      end
      incr_i = 1'b0;
      chk("op_latency", 128'(n), 128'(nw));
      chk("scoreboard_drained", 128'(sb_q.size()), 128'(0));
      chk("counter_value", mem_value(), ref_ctr);
   endtask

   task automatic wait_idx(input int target);
      int n = 0;
      while (ctr_slice_idx_o != 3'(target) && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      chk("reach_idx", 128'(ctr_slice_idx_o), 128'(target));
   endtask

   // Monitor: every write the DUT presents must match the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (ctr_we_o) begin
            $display("write idx=%0d data=%h done=%0d ovf=%0d", ctr_slice_idx_o, ctr_slice_o,
                     done_o, ovf_o);
            if (sb_q.size() == 0) begin
               chk("unexpected_write", 128'(ctr_we_o), 128'(0));
            end else begin
               e = sb_q.pop_front();
               chk("write_idx", 128'(ctr_slice_idx_o), 128'(e.idx));
               chk("write_data", 128'(ctr_slice_o), 128'(e.data));
               chk("write_done", 128'(done_o), 128'(e.done));
               chk("write_ovf", 128'(ovf_o), 128'(e.ovf));
            end
         end else if (done_o || ovf_o) begin
            chk("done_without_write", 128'({done_o, ovf_o}), 128'(0));
         end
      end
   end

   initial begin
      exp_t         e;
      logic [127:0] v;
      rst_i       = 1'b1;
      incr_i      = 1'b0;
      incr_step_i = '0;
      inc32_i     = 1'b0;
      err_i       = 1'b0;
      load_en     = 1'b0;
      load_val    = '0;
      ref_ctr     = '0;
      set_ctr(128'h0);
      @(negedge clk_i);
      chk("rst_ready", 128'(ready_o), 128'(1));
      chk("rst_outputs", 128'({done_o, ovf_o, alert_o, ctr_we_o}), 128'(0));
      chk("rst_idx", 128'(ctr_slice_idx_o), 128'(0));
      rst_i = 1'b0;

      set_ctr(128'h0000_FFFF);
      run_incr(16'h0001, 1'b0, 1'b0);
      set_ctr({128{1'b1}});
      run_incr(16'h0001, 1'b0, 1'b0);
      set_ctr(128'h1234_FFFF_FFFF);
      run_incr(16'h0001, 1'b1, 1'b0);
      set_ctr(128'h0005);
      run_incr(16'h0010, 1'b0, 1'b0);
      set_ctr(128'hABCD_0000_FFFF_FFFF_FFFF);
      run_incr(16'h0000, 1'b0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         for (int k = 0; k < N; k++)
            v[k*S +: S] = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'hFFFF;
         set_ctr(v);
         run_incr(($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 1)) : 16'($urandom),
                  1'($urandom_range(0, 1)), 1'b1);
      end

      // Fault injected mid-operation: writes up to idx 3, then locked in ERROR.
      set_ctr({128{1'b1}});
      for (int k = 0; k < 4; k++) begin
         e.idx = k; e.data = 16'h0; e.done = 1'b0; e.ovf = 1'b0;
         sb_q.push_back(e);
      end
      ref_ctr[63:0] = '0;
      @(negedge clk_i);
      incr_i = 1'b1; incr_step_i = 16'h0001; inc32_i = 1'b0;
      @(negedge clk_i);
      incr_i = 1'b0;
      wait_idx(3);
      err_i = 1'b1;
      @(negedge clk_i);
      err_i = 1'b0;
      chk("err_alert", 128'(alert_o), 128'(1));
      chk("err_quiet", 128'({ready_o, ctr_we_o, done_o, ovf_o}), 128'(0));
      incr_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         chk("err_hold_alert", 128'(alert_o), 128'(1));
         chk("err_hold_we", 128'(ctr_we_o), 128'(0));
      end
      incr_i = 1'b0;
      rst_i  = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      chk("err_exit_ready", 128'(ready_o), 128'(1));
      chk("err_exit_alert", 128'(alert_o), 128'(0));
      chk("err_scoreboard", 128'(sb_q.size()), 128'(0));
      chk("err_counter", mem_value(), ref_ctr);

      // Reset mid-operation at idx 2, then a fresh increment from idx 0.
      set_ctr({128{1'b1}});
      for (int k = 0; k < 3; k++) begin
         e.idx = k; e.data = 16'h0; e.done = 1'b0; e.ovf = 1'b0;
         sb_q.push_back(e);
      end
      ref_ctr[47:0] = '0;
      @(negedge clk_i);
      incr_i = 1'b1; incr_step_i = 16'h0001; inc32_i = 1'b0;
      @(negedge clk_i);
      incr_i = 1'b0;
      wait_idx(2);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      chk("rst_mid_ready", 128'(ready_o), 128'(1));
      chk("rst_mid_we", 128'(ctr_we_o), 128'(0));
      chk("rst_mid_idx", 128'(ctr_slice_idx_o), 128'(0));
      run_incr(16'h0001, 1'b0, 1'b0);

      repeat (3) @(negedge clk_i);
      chk("final_scoreboard", 128'(sb_q.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
